// File: rtl/csr_bank_pkg.sv
// Shared definitions for csr_bank: per-bit access kinds and bus address decode.
package csr_bank_pkg;

  typedef enum logic [1:0] {
    KIND_RW    = 2'd0,
    KIND_PULSE = 2'd1,
    KIND_W1C   = 2'd2,
    KIND_RO    = 2'd3
  } csr_kind_e;

  typedef struct packed {
    logic        mapped;
    logic [31:0] idx;
  } csr_decode_t;

  function automatic csr_kind_e csr_bit_kind(input logic rw, input logic pulse, input logic w1c);
    if (rw)    return KIND_RW;
    if (pulse) return KIND_PULSE;
    if (w1c)   return KIND_W1C;
    return KIND_RO;
  endfunction

  // Mapped only when inside the window and word aligned; idx is the word offset from base.
  function automatic csr_decode_t csr_decode(input logic [31:0] addr, input logic [31:0] base,
                                             input int unsigned num_words,
                                             input int unsigned word_bytes);
    csr_decode_t dec;
    logic [31:0] off;
    dec = '0;
    off = addr - base;
    if (addr >= base && (off % word_bytes) == 0 && (off / word_bytes) < num_words) begin
      dec.mapped = 1'b1;
      dec.idx    = off / word_bytes;
    end
    return dec;
  endfunction

endpackage

// File: rtl/csr_bank_if.sv
// Host-side register bus: byte-enable write port and 1-cycle-latency read port.
interface csr_bank_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
);
  logic                wr_en;
  logic [DATA_W/8-1:0] be;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wdata;
  logic                rd_en;
  logic [ADDR_W-1:0]   rd_addr;
  logic [DATA_W-1:0]   rdata;
  logic                rd_rdy;
  logic                addr_err;

  modport master (
    output wr_en, be, wr_addr, wdata, rd_en, rd_addr,
    input  rdata, rd_rdy, addr_err
  );

  modport slave (
    input  wr_en, be, wr_addr, wdata, rd_en, rd_addr,
    output rdata, rd_rdy, addr_err
  );
endinterface

// File: rtl/csr_reg_slice.sv
// One DATA_W-wide control/status register; each bit is RW, pulse, W1C or RO according to the masks.
module csr_reg_slice
  import csr_bank_pkg::*;
#(
  parameter int                DATA_W     = 32,
  parameter logic [DATA_W-1:0] RESET_VAL  = '0,
  parameter logic [DATA_W-1:0] RW_MASK    = '1,
  parameter logic [DATA_W-1:0] PULSE_MASK = '0,
  parameter logic [DATA_W-1:0] W1C_MASK   = '0
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic                wr_sel,
  input  logic [DATA_W/8-1:0] be,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W-1:0]   hw_in,
  input  logic [DATA_W-1:0]   hw_set,
  output logic [DATA_W-1:0]   reg_q,
  output logic [DATA_W-1:0]   pulse_q,
  output logic [DATA_W-1:0]   w1c_q,
  output logic [DATA_W-1:0]   rd_val
);

  logic [DATA_W-1:0] rw_q, rw_d, pulse_d, w1c_d;

  // Non-RW bits of rw_q reset to 0 and hold, so reg_q drives 0 at those positions.
  always_comb begin
    rw_d    = rw_q;
    pulse_d = '0;
    w1c_d   = w1c_q;
    rd_val  = '0;
    for (int b = 0; b < DATA_W; b++) begin
      case (csr_bit_kind(RW_MASK[b], PULSE_MASK[b], W1C_MASK[b]))
        KIND_RW: begin
          if (wr_sel && be[b/8]) rw_d[b] = wdata[b];
          rd_val[b] = rw_q[b];
        end
        KIND_PULSE: begin
          if (wr_sel && be[b/8]) pulse_d[b] = wdata[b];
        end
        KIND_W1C: begin
          if (hw_set[b])                          w1c_d[b] = 1'b1;
          else if (wr_sel && be[b/8] && wdata[b]) w1c_d[b] = 1'b0;
          rd_val[b] = w1c_q[b];
        end
        default: rd_val[b] = hw_in[b];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      rw_q    <= RESET_VAL & RW_MASK;
      pulse_q <= '0;
      w1c_q   <= '0;
    end else begin
      rw_q    <= rw_d;
      pulse_q <= pulse_d;
      w1c_q   <= w1c_d;
    end
  end

  assign reg_q = rw_q;

endmodule

// File: rtl/csr_bank.sv
// Parametrised CSR bank: NUM_REGS csr_reg_slice instances plus decode, read mux and response flops.
// Define CSR_IRQ_EN to add the IRQ_EN register block and a registered irq output.
module csr_bank
  import csr_bank_pkg::*;
#(
  parameter int                         NUM_REGS   = 8,
  parameter int                         DATA_W     = 32,
  parameter int                         ADDR_W     = 16,
  parameter int                         BASE_ADDR  = 0,
  parameter logic [NUM_REGS*DATA_W-1:0] RESET_VAL  = '0,
  parameter logic [NUM_REGS*DATA_W-1:0] RW_MASK    = '1,
  parameter logic [NUM_REGS*DATA_W-1:0] PULSE_MASK = '0,
  parameter logic [NUM_REGS*DATA_W-1:0] W1C_MASK   = '0
) (
  input  logic                       clk,
  input  logic                       rstb,
  csr_bank_if.slave                  bus,
  output logic [NUM_REGS*DATA_W-1:0] reg_q,
  output logic [NUM_REGS*DATA_W-1:0] pulse_q,
  output logic [NUM_REGS*DATA_W-1:0] w1c_q,
  input  logic [NUM_REGS*DATA_W-1:0] hw_in,
  input  logic [NUM_REGS*DATA_W-1:0] hw_set,
  output logic                       irq
);

  localparam int unsigned WORD_BYTES = DATA_W / 8;
`ifdef CSR_IRQ_EN
  localparam int unsigned MAP_WORDS = 2 * NUM_REGS;
`else
  localparam int unsigned MAP_WORDS = NUM_REGS;
`endif

  if (((RW_MASK & PULSE_MASK) | (RW_MASK & W1C_MASK) | (PULSE_MASK & W1C_MASK)) != '0) begin : g_mask_overlap
    $error("csr_bank: RW/PULSE/W1C masks overlap");
  end
  if ((DATA_W % 8) != 0 || ADDR_W > 32) begin : g_bad_width
    $error("csr_bank: DATA_W must be a multiple of 8 and ADDR_W at most 32");
  end

  csr_decode_t       wr_dec, rd_dec;
  logic [NUM_REGS-1:0] wr_sel;
  logic [DATA_W-1:0] slice_rd [NUM_REGS];
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rd_rdy_q, rd_rdy_d, addr_err_q, addr_err_d;

  assign wr_dec = csr_decode(32'(bus.wr_addr), 32'(BASE_ADDR), MAP_WORDS, WORD_BYTES);
  assign rd_dec = csr_decode(32'(bus.rd_addr), 32'(BASE_ADDR), MAP_WORDS, WORD_BYTES);

  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NUM_REGS; i++)
      wr_sel[i] = bus.wr_en && wr_dec.mapped && (wr_dec.idx == 32'(i));
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    csr_reg_slice #(
      .DATA_W    (DATA_W),
      .RESET_VAL (RESET_VAL[i*DATA_W +: DATA_W]),
      .RW_MASK   (RW_MASK[i*DATA_W +: DATA_W]),
      .PULSE_MASK(PULSE_MASK[i*DATA_W +: DATA_W]),
      .W1C_MASK  (W1C_MASK[i*DATA_W +: DATA_W])
    ) u_slice (
      .clk    (clk),
      .rstb   (rstb),
      .wr_sel (wr_sel[i]),
      .be     (bus.be),
      .wdata  (bus.wdata),
      .hw_in  (hw_in[i*DATA_W +: DATA_W]),
      .hw_set (hw_set[i*DATA_W +: DATA_W]),
      .reg_q  (reg_q[i*DATA_W +: DATA_W]),
      .pulse_q(pulse_q[i*DATA_W +: DATA_W]),
      .w1c_q  (w1c_q[i*DATA_W +: DATA_W]),
      .rd_val (slice_rd[i])
    );
  end

`ifdef CSR_IRQ_EN
  logic [NUM_REGS*DATA_W-1:0] irq_en_q, irq_en_d;
  logic                       irq_q, irq_d;

  // IRQ_EN word i sits at bank word NUM_REGS+i.
  always_comb begin
    irq_en_d = irq_en_q;
    for (int i = 0; i < NUM_REGS; i++)
      for (int k = 0; k < DATA_W/8; k++)
        if (bus.wr_en && wr_dec.mapped && (wr_dec.idx == 32'(NUM_REGS + i)) && bus.be[k])
          irq_en_d[i*DATA_W + k*8 +: 8] = bus.wdata[k*8 +: 8];
    irq_d = |(w1c_q & irq_en_q);
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      irq_en_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_dec.idx == 32'(i)) rd_word = slice_rd[i];
`ifdef CSR_IRQ_EN
      if (rd_dec.idx == 32'(NUM_REGS + i)) rd_word = irq_en_q[i*DATA_W +: DATA_W];
`endif
    end
    if (!rd_dec.mapped) rd_word = '0;
  end

  // Read data is captured from pre-write state, so a same-cycle write is not visible.
  always_comb begin
    rdata_d    = bus.rd_en ? rd_word : '0;
    rd_rdy_d   = bus.rd_en;
    addr_err_d = (bus.rd_en && !rd_dec.mapped) || (bus.wr_en && !wr_dec.mapped);
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      rdata_q    <= '0;
      rd_rdy_q   <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      rdata_q    <= rdata_d;
      rd_rdy_q   <= rd_rdy_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign bus.rdata    = rdata_q;
  assign bus.rd_rdy   = rd_rdy_q;
  assign bus.addr_err = addr_err_q;

endmodule

// File: tb/tb_csr_bank.sv
// Self-checking bench for csr_bank: vector table plus read scoreboard, and hand sequences for
// pulse, W1C, bad-address and reset corner cases; the IRQ checks follow CSR_IRQ_EN.
module tb_csr_bank;

  localparam int NR = 8;
  localparam int DW = 32;
  localparam int AW = 16;

  localparam logic [255:0] P_RESET = {32'h0, 32'h0, 32'hDEADBEEF, 32'h0,
                                      32'h0, 32'h000000FF, 32'h0, 32'h1F000000};
  localparam logic [255:0] P_PULSE = {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0000000F, 32'h0, 32'h0};
  localparam logic [255:0] P_W1C   = {32'h0, 32'h0, 32'h0, 32'h80000000, 32'h0, 32'h0, 32'h0, 32'h0};
  localparam logic [255:0] P_RO    = {32'h0, 32'h0, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
  localparam logic [255:0] P_RW    = ~(P_PULSE | P_W1C | P_RO);
  localparam int W1C_BIT = 4*32 + 31;

`ifdef CSR_IRQ_EN
  localparam logic HI_ERR = 1'b0;
  localparam logic [15:0] BAD_WR = 16'h0040;
`else
  localparam logic HI_ERR = 1'b1;
  localparam logic [15:0] BAD_WR = 16'h0020;
`endif

  typedef struct {
    logic        is_wr;
    logic        is_rd;
    logic [15:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic         clk;
  logic         rstb;
  logic [255:0] reg_q, pulse_q, w1c_q, hw_in, hw_set;
  logic         irq;
  int           total = 0;
  int           bad = 0;
  exp_t         sb[$];
  vec_t         tbl[$];

  csr_bank_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  csr_bank #(
    .NUM_REGS(NR), .DATA_W(DW), .ADDR_W(AW), .BASE_ADDR(0),
    .RESET_VAL(P_RESET), .RW_MASK(P_RW), .PULSE_MASK(P_PULSE), .W1C_MASK(P_W1C)
  ) dut (
    .clk(clk), .rstb(rstb), .bus(bus),
    .reg_q(reg_q), .pulse_q(pulse_q), .w1c_q(w1c_q),
    .hw_in(hw_in), .hw_set(hw_set), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [255:0] v, input int i);
    return v[i*32 +: 32];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearBus();
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.be = '0;
    bus.wr_addr = '0; bus.rd_addr = '0; bus.wdata = '0;
  endtask

  task automatic addVec(input logic w, input logic r, input logic [15:0] a, input logic [3:0] b,
                        input logic [31:0] d, input logic [31:0] er, input logic ee);
    vec_t v;
    v.is_wr = w; v.is_rd = r; v.addr = a; v.be = b; v.wdata = d; v.exp_rdata = er; v.exp_err = ee;
    tbl.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    bus.wr_en = v.is_wr; bus.wr_addr = v.addr; bus.be = v.be; bus.wdata = v.wdata;
    bus.rd_en = v.is_rd; bus.rd_addr = v.addr;
    if (v.is_rd) begin
      e.rdata = v.exp_rdata; e.err = v.exp_err;
      sb.push_back(e);
    end
    tick();
  endtask

  task automatic doWrite(input logic [15:0] a, input logic [3:0] b, input logic [31:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.be = b; bus.wdata = d;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic doRead(input logic [15:0] a, input logic [31:0] er, input logic ee);
    exp_t e;
    bus.rd_en = 1'b1; bus.rd_addr = a;
    e.rdata = er; e.err = ee;
    sb.push_back(e);
    tick();
    bus.rd_en = 1'b0;
  endtask

  // Scoreboard: every rd_rdy pops one expectation; idle cycles must show rdata=0.
  always @(negedge clk) begin
    exp_t e;
    if (bus.rd_rdy) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_rd_rdy", 32'(bus.rd_rdy), 32'h0);
      end else begin
        e = sb.pop_front();
        checkOutput("rd_data", bus.rdata, e.rdata);
        checkOutput("rd_addr_err", 32'(bus.addr_err), 32'(e.err));
      end
    end else begin
      checkOutput("rdata_idle", bus.rdata, 32'h0);
    end
  end

  initial begin
    clearBus();
    rstb   = 1'b0;
    hw_set = '0;
    hw_in  = {32'hC3C3C3C3, 32'hC3C3C3C3, 32'h12345678, 32'hC3C3C3C3,
              32'hC3C3C3C3, 32'hC3C3C3C3, 32'hC3C3C3C3, 32'hC3C3C3C3};

    addVec(0, 1, 16'h00, 4'h0, 32'h0,        32'h1F000000, 1'b0);
    addVec(1, 0, 16'h04, 4'b0101, 32'hA5A5A5A5, 32'h0,     1'b0);
    addVec(0, 1, 16'h04, 4'h0, 32'h0,        32'h00A500A5, 1'b0);
    addVec(0, 1, 16'h14, 4'h0, 32'h0,        32'h12345678, 1'b0);
    addVec(1, 0, 16'h14, 4'hF, 32'hFFFFFFFF, 32'h0,        1'b0);
    addVec(0, 1, 16'h14, 4'h0, 32'h0,        32'h12345678, 1'b0);
    addVec(0, 1, 16'h20, 4'h0, 32'h0,        32'h0,        HI_ERR);
    addVec(0, 1, 16'h06, 4'h0, 32'h0,        32'h0,        1'b1);
    addVec(1, 1, 16'h0C, 4'hF, 32'h11223344, 32'h0,        1'b0);
    addVec(0, 1, 16'h0C, 4'h0, 32'h0,        32'h11223344, 1'b0);
    addVec(1, 0, 16'h00, 4'b1000, 32'hAB000000, 32'h0,     1'b0);
    addVec(0, 1, 16'h00, 4'h0, 32'h0,        32'hAB000000, 1'b0);
    addVec(1, 0, 16'h08, 4'hF, 32'h12345675, 32'h0,        1'b0);
    addVec(0, 1, 16'h08, 4'h0, 32'h0,        32'h12345670, 1'b0);
    addVec(0, 1, 16'h1C, 4'h0, 32'h0,        32'h0,        1'b0);
    addVec(0, 1, 16'h24, 4'h0, 32'h0,        32'h0,        HI_ERR);

    #12;
    checkOutput("rst_reg0", word_of(reg_q, 0), 32'h1F000000);
    checkOutput("rst_reg2_masked", word_of(reg_q, 2), 32'h000000F0);
    checkOutput("rst_reg5_ro", word_of(reg_q, 5), 32'h0);
    checkOutput("rst_pulse", word_of(pulse_q, 2), 32'h0);
    checkOutput("rst_w1c", word_of(w1c_q, 4), 32'h0);
    checkOutput("rst_rd_rdy", 32'(bus.rd_rdy), 32'h0);
    checkOutput("rst_addr_err", 32'(bus.addr_err), 32'h0);
    checkOutput("rst_irq", 32'(irq), 32'h0);
    @(negedge clk);
    rstb = 1'b1;
    tick();

    foreach (tbl[i]) applyStimulus(tbl[i]);
    clearBus();
    tick();
    tick();
    checkOutput("regq_w0", word_of(reg_q, 0), 32'hAB000000);
    checkOutput("regq_w1", word_of(reg_q, 1), 32'h00A500A5);
    checkOutput("regq_w2", word_of(reg_q, 2), 32'h12345670);
    checkOutput("regq_w3", word_of(reg_q, 3), 32'h11223344);
    checkOutput("regq_w5_ro", word_of(reg_q, 5), 32'h0);

    // Single pulse then back-to-back pulses.
    doWrite(16'h08, 4'b0001, 32'h5);
    @(negedge clk) checkOutput("pulse_on", word_of(pulse_q, 2), 32'h5);
    @(negedge clk) checkOutput("pulse_off", word_of(pulse_q, 2), 32'h0);
    tick();
    bus.wr_en = 1'b1; bus.wr_addr = 16'h08; bus.be = 4'b0001; bus.wdata = 32'h3;
    tick();
    bus.wdata = 32'hA;
    @(negedge clk) checkOutput("pulse_b2b_1", word_of(pulse_q, 2), 32'h3);
    tick();
    bus.wr_en = 1'b0;
    @(negedge clk) checkOutput("pulse_b2b_2", word_of(pulse_q, 2), 32'hA);
    @(negedge clk) checkOutput("pulse_b2b_off", word_of(pulse_q, 2), 32'h0);
    tick();
    doRead(16'h08, 32'h12345600, 1'b0);

    // W1C: set, set-beats-clear, partial byte enable, clear.
    hw_set[W1C_BIT] = 1'b1;
    tick();
    hw_set[W1C_BIT] = 1'b0;
    @(negedge clk) checkOutput("w1c_set", 32'(w1c_q[W1C_BIT]), 32'h1);
    tick();
    doRead(16'h10, 32'h80000000, 1'b0);
    hw_set[W1C_BIT] = 1'b1;
    doWrite(16'h10, 4'b1000, 32'h80000000);
    hw_set[W1C_BIT] = 1'b0;
    @(negedge clk) checkOutput("w1c_set_wins", 32'(w1c_q[W1C_BIT]), 32'h1);
    tick();
    doWrite(16'h10, 4'b0111, 32'h80000000);
    @(negedge clk) checkOutput("w1c_wrong_be", 32'(w1c_q[W1C_BIT]), 32'h1);
    tick();
    doWrite(16'h10, 4'b1000, 32'h80000000);
    @(negedge clk) checkOutput("w1c_clear", 32'(w1c_q[W1C_BIT]), 32'h0);
    tick();
    doRead(16'h10, 32'h0, 1'b0);

    // Unmapped and misaligned writes flag addr_err and change nothing.
    doWrite(BAD_WR, 4'hF, 32'hFFFFFFFF);
    @(negedge clk) checkOutput("bad_wr_err", 32'(bus.addr_err), 32'h1);
    @(negedge clk) checkOutput("bad_wr_err_end", 32'(bus.addr_err), 32'h0);
    checkOutput("bad_wr_w0", word_of(reg_q, 0), 32'hAB000000);
    tick();
    doWrite(16'h05, 4'hF, 32'hFFFFFFFF);
    @(negedge clk) checkOutput("misalign_wr_err", 32'(bus.addr_err), 32'h1);
    checkOutput("misalign_wr_w1", word_of(reg_q, 1), 32'h00A500A5);
    tick();
    bus.wr_en = 1'b1; bus.wr_addr = 16'h22; bus.be = 4'hF; bus.wdata = 32'hFFFFFFFF;
    doRead(16'h04, 32'h00A500A5, 1'b1);
    bus.wr_en = 1'b0;
    tick();

`ifdef CSR_IRQ_EN
    doWrite(16'h30, 4'b1000, 32'h80000000);
    doRead(16'h30, 32'h80000000, 1'b0);
    hw_set[W1C_BIT] = 1'b1;
    tick();
    hw_set[W1C_BIT] = 1'b0;
    @(negedge clk) checkOutput("irq_latency", 32'(irq), 32'h0);
    @(negedge clk) checkOutput("irq_on", 32'(irq), 32'h1);
    tick();
    doWrite(16'h10, 4'b1000, 32'h80000000);
    @(negedge clk) checkOutput("irq_hold", 32'(irq), 32'h1);
    @(negedge clk) checkOutput("irq_off", 32'(irq), 32'h0);
    tick();
`else
    hw_set[W1C_BIT] = 1'b1;
    tick();
    hw_set[W1C_BIT] = 1'b0;
    tick();
    checkOutput("irq_tied", 32'(irq), 32'h0);
    doWrite(16'h10, 4'b1000, 32'h80000000);
`endif

    // Reset lands while a read is presented: no response must follow.
    hw_set[W1C_BIT] = 1'b1;
    tick();
    hw_set[W1C_BIT] = 1'b0;
    bus.rd_en = 1'b1; bus.rd_addr = 16'h04;
    #2 rstb = 1'b0;
    #1;
    checkOutput("midrst_reg0", word_of(reg_q, 0), 32'h1F000000);
    checkOutput("midrst_reg3", word_of(reg_q, 3), 32'h0);
    checkOutput("midrst_w1c", 32'(w1c_q[W1C_BIT]), 32'h0);
    bus.rd_en = 1'b0;
    tick();
    rstb = 1'b1;
    tick();
    checkOutput("midrst_no_rsp", 32'(bus.rd_rdy), 32'h0);
    doRead(16'h00, 32'h1F000000, 1'b0);
    tick();
    tick();
    checkOutput("sb_drained", 32'(sb.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/csr_bank.md
Name: csr_bank

Overview:
Parametrised control/status register bank that replaces hand-written per-project register files. It provides NUM_REGS word registers with per-bit access kinds selected by mask parameters: RW storage, write-pulse (self-clearing), W1C sticky status and RO hardware inputs. It sits between the host bus bridge (byte-enable write port, 1-cycle read port) and datapath blocks such as SPI, ADC FIFO and DAC control.

Parameters:
NUM_REGS, 8, number of registers; register i sits at byte address BASE_ADDR + i*(DATA_W/8)
DATA_W, 32, register width; must be a multiple of 8
ADDR_W, 16, bus address width
BASE_ADDR, 0, byte address of register 0
RESET_VAL, all 0, NUM_REGS*DATA_W packed reset values for RW bits
RW_MASK, all 1, packed; 1 = bit is host read/write storage
PULSE_MASK, all 0, packed; 1 = bit is write-only single-cycle pulse
W1C_MASK, all 0, packed; 1 = sticky status bit, set by hardware, cleared by host writing 1
(Any bit not set in any mask is RO and reads hw_in. Masks must not overlap; this is checked by an elaboration assertion.)

Ports:
clk  in  1  clock
rstb  in  1  asynchronous active-low reset
wr_en  in  1  write strobe
be  in  DATA_W/8  byte enables
wr_addr  in  ADDR_W  write byte address
wdata  in  DATA_W  write data
rd_en  in  1  read strobe
rd_addr  in  ADDR_W  read byte address
rdata  out  DATA_W  read data, valid when rd_rdy is high
rd_rdy  out  1  read response strobe
addr_err  out  1  unmapped-access flag, qualified by rd_rdy, or pulsed on a bad write
reg_q  out  NUM_REGS*DATA_W  RW bit values; all other bit positions drive 0
pulse_q  out  NUM_REGS*DATA_W  pulse bit outputs
w1c_q  out  NUM_REGS*DATA_W  sticky status bit values
hw_in  in  NUM_REGS*DATA_W  RO bit sources
hw_set  in  NUM_REGS*DATA_W  per-bit set requests for W1C bits
irq  out  1  interrupt; see Optional Feature

Behaviour:
- Reset values: reg_q=RESET_VAL&RW_MASK. pulse_q, w1c_q, rdata, rd_rdy, addr_err, irq are all 0.
- Decode: an address is mapped if BASE_ADDR <= addr < BASE_ADDR+NUM_REGS*(DATA_W/8) and it is aligned to DATA_W/8. Every other address is unmapped.
- RW write: with wr_en, a mapped address and be[k], RW bits in byte k take wdata. They are visible on reg_q the next cycle.
- Pulse: on a write with be[k], pulse bits in byte k take wdata for exactly one cycle. In every cycle without such a write, pulse_q=0. Back-to-back writes give back-to-back pulses.
- W1C: a bit sets when hw_set=1 and clears on a write with be[k] and wdata bit=1. If hw_set and the clear land in the same cycle, set wins.
- RO: writes are ignored.
- Read: when rd_en is sampled, rdata and rd_rdy are registered on the next edge (latency 1). Read-back sources per bit kind:
  - RW: stored value
  - Pulse: 0
  - W1C: sticky value
  - RO: hw_in sampled in the rd_en cycle
- rd_rdy is high for exactly one cycle per rd_en. Consecutive rd_en cycles give a response every cycle.
- When rd_rdy=0, rdata=0.
- Read and write to the same address in the same cycle: the read returns the pre-write value.
- Unmapped write: no state changes, and addr_err pulses for 1 cycle.
- Unmapped read: rdata=0, with addr_err=1 alongside rd_rdy.
- If rd_en and an unmapped wr_en occur in the same cycle, addr_err is the OR of the two conditions.
- Asynchronous reset mid-access: all state returns to reset values immediately. No response is issued for a read in flight.

Optional Feature:
CSR_IRQ_EN defined:
- An extra RW register IRQ_EN (DATA_W bits per register, packed NUM_REGS*DATA_W, reset 0) is mapped at addresses following the bank; its address space is NUM_REGS words long.
- irq is registered as the OR of (w1c_q & irq_en), giving 1-cycle latency after the sticky bit sets.
Undefined:
- No IRQ_EN storage exists; those addresses are unmapped.
- irq is tied to 0.

Decomposition:
- csr_bank_pkg holds the access-kind constants (RW, PULSE, W1C, RO), a function that derives the per-bit kind from the masks, and the address-to-index/mapped decode function.
- One sub-module, csr_reg_slice, implements a single DATA_W register with all four bit kinds. csr_bank instantiates it NUM_REGS times with generate and adds decode, the read mux and the response registers.

Test Plan:
1. Reset with RESET_VAL reg0=0x1F00_0000, then read 0x0 -> one cycle later rd_rdy=1, rdata=0x1F00_0000, addr_err=0.
2. Write 0xA5A5_A5A5 to 0x4 with be=4'b0101 over reset value 0 -> reg_q word1=0x00A5_00A5, confirmed by read-back.
3. PULSE_MASK reg2=0xF: write 0x5 to 0x8, then idle -> pulse_q word2=0x5 for exactly 1 cycle, then 0. A read of 0x8 returns 0.
4. W1C reg4 bit31: pulse hw_set -> bit reads 1. Write 0x8000_0000 in the same cycle as hw_set -> bit stays 1. Write 0x8000_0000 with hw_set low -> bit reads 0.
5. NUM_REGS=8: read 0x20 and 0x6 -> rdata=0, addr_err=1. Write 0x20 -> addr_err pulse, no register changes.
6. CSR_IRQ_EN defined: set irq_en word4 bit31, then pulse hw_set bit31 -> irq=1 the next cycle. W1C clear -> irq=0 the cycle after.
